// File: rtl/dll_lock_seq_pkg.sv
// Shared types for the FMDLL acquisition/lock sequencer: FSM states, phase-detector
// sample classes and small decode helpers used by the top level.
package dll_lock_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SAR    = 3'd1,
      ST_TRACK  = 3'd2,
      ST_LOCKED = 3'd3,
      ST_HCLR   = 3'd4,
      ST_FAIL   = 3'd5
   } seq_state_e;

   typedef enum logic [1:0] {
      PD_HOLD = 2'b00,
      PD_DN   = 2'b01,
      PD_UP   = 2'b10,
      PD_BOTH = 2'b11
   } pd_sample_e;

   function automatic pd_sample_e pd_classify(input logic up, input logic dn);
      pd_sample_e s;
      case ({up, dn})
         2'b10:   s = PD_UP;
         2'b01:   s = PD_DN;
         2'b11:   s = PD_BOTH;
         default: s = PD_HOLD;
      endcase
      return s;
   endfunction

   // States in which a harmonic-lock flag aborts the sequence
   function automatic logic harm_sensitive(input seq_state_e st);
      logic r;
      case (st)
         ST_SAR, ST_TRACK, ST_LOCKED: r = 1'b1;
         default:                     r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic is_busy_state(input seq_state_e st);
      logic r;
      case (st)
         ST_SAR, ST_TRACK, ST_LOCKED, ST_HCLR: r = 1'b1;
         default:                              r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/dll_lock_seq_sync_2ff.sv
// Two-flop synchroniser for the asynchronous harmonic-lock flag from the detector.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_r;
   logic sync_r;

   // Two-stage capture; first stage may go metastable, second is used by the FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_r <= 1'b0;
         sync_r <= 1'b0;
      end else begin
         meta_r <= d;
         sync_r <= meta_r;
      end
   end

   assign q = sync_r;

endmodule

// File: rtl/dll_lock_seq.sv
// FMDLL lock sequencer: SAR coarse search of the delay-line code, PD-driven fine
// tracking with lock qualification, and harmonic-lock abort with bounded retry.
module dll_lock_seq
   import dll_lock_seq_pkg::*;
#(
   parameter int unsigned CODE_W     = 6,
   parameter int unsigned SETTLE_CYC = 4,
   parameter int unsigned LOCK_CNT   = 16,
   parameter int unsigned MAX_RETRY  = 3
) (
   input  logic              clk_ext,
   input  logic              rst_n,
   input  logic              start,
   input  logic              reset_pd,
   input  logic              pd_up,
   input  logic              pd_dn,
   output logic [CODE_W-1:0] dl_code,
   output logic              sel,
   output logic              pd_en,
   output logic              locked,
   output logic              fail,
   output logic              busy
);

   localparam int SET_W = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
   localparam int BIT_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
   localparam int LCK_W = $clog2(LOCK_CNT + 1);
   localparam int RTY_W = $clog2(MAX_RETRY + 1);

   localparam logic [CODE_W-1:0] CODE_MID  = {1'b1, {(CODE_W-1){1'b0}}};
   localparam logic [CODE_W-1:0] CODE_MAX  = {CODE_W{1'b1}};
   localparam logic [CODE_W-1:0] CODE_MIN  = {CODE_W{1'b0}};
   localparam logic [CODE_W-1:0] CODE_ONE  = CODE_W'(1);
   localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE_CYC);
   localparam logic [SET_W-1:0]  SET_ZERO  = {SET_W{1'b0}};
   localparam logic [SET_W-1:0]  SET_ONE   = SET_W'(1);
   localparam logic [BIT_W-1:0]  BIT_TOP   = BIT_W'(CODE_W - 1);
   localparam logic [BIT_W-1:0]  BIT_ZERO  = {BIT_W{1'b0}};
   localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
   localparam logic [LCK_W-1:0]  LCK_LAST  = LCK_W'(LOCK_CNT);
   localparam logic [LCK_W-1:0]  LCK_ZERO  = {LCK_W{1'b0}};
   localparam logic [LCK_W-1:0]  LCK_ONE   = LCK_W'(1);
   localparam logic [RTY_W-1:0]  RTY_LAST  = RTY_W'(MAX_RETRY);
   localparam logic [RTY_W-1:0]  RTY_ZERO  = {RTY_W{1'b0}};
   localparam logic [RTY_W-1:0]  RTY_ONE   = RTY_W'(1);

   seq_state_e        state_r;
   logic [CODE_W-1:0] dl_code_r;
   logic [SET_W-1:0]  settle_r;
   logic [BIT_W-1:0]  bit_r;
   logic [LCK_W-1:0]  lock_cnt_r;
   logic [RTY_W-1:0]  retry_r;
   logic              sel_r;
   logic              pd_en_r;
   logic              locked_r;
   logic              fail_r;
   logic              busy_r;

   logic              sync_pd_s;
   pd_sample_e        pd_s;
   logic              decide_s;
   logic              harm_s;
   logic              hold_s;
   logic              sat_req_s;
   logic [CODE_W-1:0] code_trk_s;
   logic [LCK_W-1:0]  lock_next_s;

   sync_2ff u_sync_reset_pd (
      .clk   (clk_ext),
      .rst_n (rst_n),
      .d     (reset_pd),
      .q     (sync_pd_s)
   );

   // Tracking decision decode: next code, saturation request and hold detection
   always_comb begin
      pd_s        = pd_classify(pd_up, pd_dn);
      decide_s    = (settle_r == SET_LAST);
      harm_s      = sync_pd_s & harm_sensitive(state_r);
      hold_s      = (pd_s == PD_HOLD) || (pd_s == PD_BOTH);
      lock_next_s = lock_cnt_r + LCK_ONE;
      sat_req_s   = 1'b0;
      code_trk_s  = dl_code_r;
      case (pd_s)
         PD_UP: begin
            if (dl_code_r == CODE_MAX) begin
               sat_req_s = 1'b1;
            end else begin
               code_trk_s = dl_code_r + CODE_ONE;
            end
         end
         PD_DN: begin
            if (dl_code_r == CODE_MIN) begin
               sat_req_s = 1'b1;
            end else begin
               code_trk_s = dl_code_r - CODE_ONE;
            end
         end
         default: begin
            sat_req_s  = 1'b0;
            code_trk_s = dl_code_r;
         end
      endcase
   end

   // Sequencer FSM with all counters and registered outputs
   always_ff @(posedge clk_ext or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         dl_code_r  <= CODE_MID;
         settle_r   <= SET_ZERO;
         bit_r      <= BIT_TOP;
         lock_cnt_r <= LCK_ZERO;
         retry_r    <= RTY_ZERO;
         sel_r      <= 1'b0;
         pd_en_r    <= 1'b0;
         locked_r   <= 1'b0;
         fail_r     <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         sel_r <= 1'b0;
         if (harm_s) begin
            // Harmonic abort outranks any decision falling in the same cycle
            state_r    <= ST_HCLR;
            sel_r      <= 1'b1;
            pd_en_r    <= 1'b0;
            locked_r   <= 1'b0;
            busy_r     <= 1'b1;
            settle_r   <= SET_ZERO;
            lock_cnt_r <= LCK_ZERO;
            retry_r    <= retry_r + RTY_ONE;
         end else begin
            case (state_r)
               ST_IDLE, ST_FAIL: begin
                  if (start) begin
                     state_r    <= ST_SAR;
                     dl_code_r  <= CODE_MID;
                     bit_r      <= BIT_TOP;
                     settle_r   <= SET_ZERO;
                     lock_cnt_r <= LCK_ZERO;
                     retry_r    <= (state_r == ST_FAIL) ? RTY_ZERO : retry_r;
                     sel_r      <= 1'b1;
                     busy_r     <= 1'b1;
                     fail_r     <= 1'b0;
                     pd_en_r    <= 1'b0;
                     locked_r   <= 1'b0;
                  end
               end
               ST_SAR: begin
                  if (decide_s) begin
                     settle_r         <= SET_ZERO;
                     dl_code_r[bit_r] <= pd_up;
                     if (bit_r == BIT_ZERO) begin
                        state_r    <= ST_TRACK;
                        pd_en_r    <= 1'b1;
                        lock_cnt_r <= LCK_ZERO;
                     end else begin
                        bit_r <= bit_r - BIT_ONE;
                     end
                  end else begin
                     settle_r <= settle_r + SET_ONE;
                     if (settle_r == SET_ZERO) begin
                        dl_code_r[bit_r] <= 1'b1;
                     end
                  end
               end
               ST_TRACK: begin
                  if (decide_s) begin
                     settle_r  <= SET_ZERO;
                     dl_code_r <= code_trk_s;
                     if (hold_s) begin
                        lock_cnt_r <= lock_next_s;
                        if (lock_next_s == LCK_LAST) begin
                           state_r  <= ST_LOCKED;
                           locked_r <= 1'b1;
                        end
                     end else begin
                        // Applied or saturated correction restarts lock qualification
                        lock_cnt_r <= LCK_ZERO;
                     end
                  end else begin
                     settle_r <= settle_r + SET_ONE;
                  end
               end
               ST_LOCKED: begin
                  if (decide_s) begin
                     settle_r <= SET_ZERO;
                     if (sat_req_s) begin
                        state_r    <= ST_TRACK;
                        locked_r   <= 1'b0;
                        lock_cnt_r <= LCK_ZERO;
                     end else begin
                        dl_code_r <= code_trk_s;
                        if (!hold_s) begin
                           lock_cnt_r <= LCK_ZERO;
                        end else if (lock_cnt_r != LCK_LAST) begin
                           lock_cnt_r <= lock_next_s;
                        end
                     end
                  end else begin
                     settle_r <= settle_r + SET_ONE;
                  end
               end
               ST_HCLR: begin
                  if (retry_r == RTY_LAST) begin
                     state_r <= ST_FAIL;
                     fail_r  <= 1'b1;
                     busy_r  <= 1'b0;
                  end else if (!sync_pd_s && !sel_r) begin
                     // Waiting for sel to drop keeps the clear and arm pulses distinct
                     state_r    <= ST_SAR;
                     dl_code_r  <= CODE_MID;
                     bit_r      <= BIT_TOP;
                     settle_r   <= SET_ZERO;
                     lock_cnt_r <= LCK_ZERO;
                     sel_r      <= 1'b1;
                  end
               end
               default: begin
                  state_r    <= ST_IDLE;
                  dl_code_r  <= CODE_MID;
                  settle_r   <= SET_ZERO;
                  bit_r      <= BIT_TOP;
                  lock_cnt_r <= LCK_ZERO;
                  retry_r    <= RTY_ZERO;
                  pd_en_r    <= 1'b0;
                  locked_r   <= 1'b0;
                  fail_r     <= 1'b0;
                  busy_r     <= is_busy_state(ST_IDLE);
               end
            endcase
         end
      end
   end

   assign dl_code = dl_code_r;
   assign sel     = sel_r;
   assign pd_en   = pd_en_r;
   assign locked  = locked_r;
   assign fail    = fail_r;
   assign busy    = busy_r;

endmodule

// File: tb/tb_dll_lock_seq.sv
// Directed bench for dll_lock_seq: a PD model centred on a target code drives pd_up/pd_dn,
// and hand-derived cycle counts give every expected output value.
module tb_dll_lock_seq;

   logic       clk_ext = 1'b0;
   logic       rst_n;
   logic       start;
   logic       reset_pd;
   logic       pd_up;
   logic       pd_dn;
   logic [5:0] dl_code;
   logic       sel;
   logic       pd_en;
   logic       locked;
   logic       fail;
   logic       busy;

   int n_checks  = 0;
   int n_pass    = 0;
   int sel_rises = 0;
   int target    = 37;
   int pd_force  = 0;   // 0: model, 1: up only, 2: down only

   dll_lock_seq dut (
      .clk_ext  (clk_ext),
      .rst_n    (rst_n),
      .start    (start),
      .reset_pd (reset_pd),
      .pd_up    (pd_up),
      .pd_dn    (pd_dn),
      .dl_code  (dl_code),
      .sel      (sel),
      .pd_en    (pd_en),
      .locked   (locked),
      .fail     (fail),
      .busy     (busy)
   );

   always #5 clk_ext = ~clk_ext;

   // Both flags set exactly at the target code, so a locked loop sees hold decisions
   assign pd_up = (pd_force == 1) ? 1'b1 : (pd_force == 2) ? 1'b0 : (int'(dl_code) <= target);
   assign pd_dn = (pd_force == 1) ? 1'b0 : (pd_force == 2) ? 1'b1 : (int'(dl_code) >= target);

   always @(posedge sel) sel_rises++;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_ext);
         #1;
      end
   endtask

   task automatic check_reset_outs(input string tag);
      check_val(tag, {21'd0, dl_code, sel, pd_en, locked, fail, busy}, {21'd0, 6'd32, 5'b00000});
   endtask

   task automatic do_reset();
      start    = 1'b0;
      reset_pd = 1'b0;
      pd_force = 0;
      rst_n    = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(2);
   endtask

   task automatic start_arm();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   // Called just after the arm edge; follows SAR (30 cycles) and 16 hold decisions (80 cycles)
   task automatic acq_check(input string tag, input int exp_code);
      int s0;
      s0 = sel_rises;
      check_val({tag, " arm sel"}, sel, 1);
      check_val({tag, " arm busy"}, busy, 1);
      check_val({tag, " arm code"}, dl_code, 32);
      tick(1);
      check_val({tag, " sel width"}, sel, 0);
      tick(28);
      check_val({tag, " pd_en in sar"}, pd_en, 0);
      tick(1);
      check_val({tag, " sar code"}, dl_code, exp_code);
      check_val({tag, " pd_en track"}, pd_en, 1);
      tick(79);
      check_val({tag, " not yet locked"}, locked, 0);
      tick(1);
      check_val({tag, " locked"}, locked, 1);
      check_val({tag, " single sel"}, sel_rises - s0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      reset_pd = 1'b0;
      tick(2);
      check_reset_outs("reset");
      rst_n = 1'b1;
      tick(2);
      check_reset_outs("idle");

      // Acquire at 37, then follow a target move to 39 while staying locked
      target = 37;
      start_arm();
      acq_check("t1", 37);
      target = 39;
      tick(4);
      check_val("t1 pre-step code", dl_code, 37);
      tick(1);
      check_val("t1 step code", dl_code, 38);
      check_val("t1 stays locked", locked, 1);
      tick(5);
      check_val("t1 second step", dl_code, 39);
      tick(5);
      check_val("t1 hold at 39", dl_code, 39);

      // Top boundary: saturated up request drops lock and never wraps
      do_reset();
      target = 63;
      start_arm();
      acq_check("t2", 63);
      pd_force = 1;
      tick(4);
      check_val("t2 locked before decision", locked, 1);
      tick(1);
      check_val("t2 lock dropped", locked, 0);
      check_val("t2 no wrap", dl_code, 63);
      check_val("t2 still tracking", pd_en, 1);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      check_val("t2 start ignored sel", sel, 0);
      tick(100);
      check_val("t2 never relocks", locked, 0);
      check_val("t2 code held max", dl_code, 63);

      // Bottom boundary: pd_up=pd_dn=1 at code 0 holds and locks; down request saturates
      do_reset();
      target = 0;
      start_arm();
      acq_check("t5", 0);
      pd_force = 2;
      tick(5);
      check_val("t5 lock dropped", locked, 0);
      check_val("t5 no wrap", dl_code, 0);

      // Harmonic event during SAR bit 3, then twice in LOCKED to exhaust retries
      do_reset();
      target = 37;
      start_arm();
      tick(11);
      reset_pd = 1'b1;
      tick(1);
      reset_pd = 1'b0;
      tick(1);
      check_val("t3 sync latency", sel, 0);
      tick(1);
      check_val("t3 hclr sel", sel, 1);
      check_val("t3 hclr busy", busy, 1);
      check_val("t3 hclr pd_en", pd_en, 0);
      tick(1);
      check_val("t3 sel one cycle", sel, 0);
      check_val("t3 no fail", fail, 0);
      tick(1);
      acq_check("t3 restart", 37);

      reset_pd = 1'b1;
      tick(1);
      reset_pd = 1'b0;
      tick(1);
      check_val("t4 still locked", locked, 1);
      tick(1);
      check_val("t4 hclr2 sel", sel, 1);
      check_val("t4 hclr2 unlock", locked, 0);
      check_val("t4 hclr2 pd_en", pd_en, 0);
      tick(1);
      check_val("t4 retry2 no fail", fail, 0);
      tick(1);
      acq_check("t4 restart2", 37);

      reset_pd = 1'b1;
      tick(1);
      reset_pd = 1'b0;
      tick(2);
      check_val("t4 hclr3 sel", sel, 1);
      check_val("t4 hclr3 no fail yet", fail, 0);
      tick(1);
      check_val("t4 fail", fail, 1);
      check_val("t4 fail busy", busy, 0);
      check_val("t4 fail sel", sel, 0);
      check_val("t4 fail code held", dl_code, 37);
      tick(3);
      check_val("t4 fail sticky", fail, 1);
      start_arm();
      check_val("t4 fail cleared", fail, 0);
      acq_check("t4 after fail", 37);

      // Asynchronous reset mid-TRACK and mid-HCLR
      do_reset();
      start_arm();
      tick(40);
      check_val("t6 in track", pd_en, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outs("t6 reset in track");
      tick(1);
      rst_n = 1'b1;
      tick(1);
      start_arm();
      tick(5);
      reset_pd = 1'b1;
      tick(3);
      check_val("t6 in hclr", sel, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outs("t6 reset in hclr");
      reset_pd = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(2);
      check_reset_outs("t6 idle after hclr reset");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
